// File: rtl/zs_packer_if.sv
// Handshake and BRAM-write bundle between the dense A stream, the zero-skip
// packer and the shared BRAM it fills.
interface zs_packer_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 32
);
  logic                       start;
  logic                       in_valid;
  logic [DATA_WIDTH-1:0]      in_data;
  logic                       in_ready;
  logic [BRAM_ADDR_WIDTH-1:0] bram_addr;
  logic [BRAM_DATA_WIDTH-1:0] bram_wrdata;
  logic [DATA_WIDTH/8-1:0]    bram_we;
  logic                       done;
  logic                       overflow;

  // Upstream producer / BRAM-side observer.
  modport master (
    output start, in_valid, in_data,
    input  in_ready, bram_addr, bram_wrdata, bram_we, done, overflow
  );

  // The packer itself.
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, bram_addr, bram_wrdata, bram_we, done, overflow
  );
endinterface

// File: rtl/zs_packer.sv
// Zero-skip packer: compresses a row-major dense 8x8 A matrix into fixed
// NNZ_MAX-slot rows plus a 64-bit occupancy mask in the shared BRAM.
module zs_packer #(
  parameter int DATA_WIDTH      = 32,
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int LINE_SIZE       = 8,
  parameter int NNZ_MAX         = 4,
  parameter int MASK_BASE       = 96
) (
  input  logic        clk,
  input  logic        resetn,
  zs_packer_if.slave  bus
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int MASK_W = LINE_SIZE * LINE_SIZE;
  localparam int MIDX_W = $clog2(MASK_W);
  localparam int ROW_W  = $clog2(LINE_SIZE);
  localparam int SLOT_W = $clog2(NNZ_MAX + 1);
  localparam int AW     = BRAM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_PAD, S_MASK0, S_MASK1, S_DONE
  } state_e;

  state_e                     state_q;
  logic [ROW_W-1:0]           row_q;
  logic [ROW_W-1:0]           col_q;
  logic [SLOT_W-1:0]          slot_q;
  logic [MASK_W-1:0]          mask_q;
  logic                       overflow_q;
  logic                       in_ready_q;
  logic                       we_q;
  logic                       done_q;
  logic [AW-1:0]              addr_q;
  logic [BRAM_DATA_WIDTH-1:0] wrdata_q;

  function automatic logic [AW-1:0] word_to_byte(input logic [AW-1:0] word);
    return word * AW'(BYTES);
  endfunction

  logic              hs;
  logic              nz;
  logic              can_store;
  logic              row_last;
  logic              col_last;
  logic [SLOT_W-1:0] slot_inc;
  logic [SLOT_W-1:0] slot_upd;
  logic [AW-1:0]     slot_addr;
  logic [MIDX_W-1:0] mask_idx;

  assign hs        = (state_q == S_ACCEPT) && in_ready_q && bus.in_valid;
  assign nz        = (bus.in_data != '0);
  assign can_store = (slot_q < SLOT_W'(NNZ_MAX));
  assign row_last  = (row_q == ROW_W'(LINE_SIZE - 1));
  assign col_last  = (col_q == ROW_W'(LINE_SIZE - 1));
  assign slot_inc  = slot_q + SLOT_W'(1);
  assign slot_upd  = (nz && can_store) ? slot_inc : slot_q;
  assign slot_addr = word_to_byte(AW'(row_q) * AW'(NNZ_MAX) + AW'(slot_q));
  assign mask_idx  = MIDX_W'(row_q) * MIDX_W'(LINE_SIZE) + MIDX_W'(col_q);

  // NOTE: every state bit is updated with <= so all registers sample the
  // same pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      slot_q     <= '0;
      mask_q     <= '0;
      overflow_q <= 1'b0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      wrdata_q   <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q    <= S_ACCEPT;
            in_ready_q <= 1'b1;
            row_q      <= '0;
            col_q      <= '0;
            slot_q     <= '0;
            mask_q     <= '0;
            overflow_q <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (hs) begin
            if (nz && can_store) begin
              we_q             <= 1'b1;
              addr_q           <= slot_addr;
              wrdata_q         <= bus.in_data;
              mask_q[mask_idx] <= 1'b1;
            end
            // Dropped elements keep a clear mask bit, so the consumer skips them.
            if (nz && !can_store) overflow_q <= 1'b1;
            slot_q <= slot_upd;
            col_q  <= col_last ? '0 : col_q + ROW_W'(1);
            if (col_last) begin
              if (slot_upd != SLOT_W'(NNZ_MAX)) begin
                state_q    <= S_PAD;
                in_ready_q <= 1'b0;
              end else if (!row_last) begin
                row_q  <= row_q + ROW_W'(1);
                slot_q <= '0;
              end else begin
                state_q    <= S_MASK0;
                in_ready_q <= 1'b0;
              end
            end
          end
        end
        S_PAD: begin
          we_q     <= 1'b1;
          addr_q   <= slot_addr;
          wrdata_q <= '0;
          if (slot_q == SLOT_W'(NNZ_MAX - 1)) begin
            slot_q <= '0;
            if (row_last) begin
              state_q <= S_MASK0;
            end else begin
              row_q      <= row_q + ROW_W'(1);
              state_q    <= S_ACCEPT;
              in_ready_q <= 1'b1;
            end
          end else begin
            slot_q <= slot_inc;
          end
        end
        S_MASK0: begin
          we_q     <= 1'b1;
          addr_q   <= word_to_byte(AW'(MASK_BASE));
          wrdata_q <= mask_q[BRAM_DATA_WIDTH-1:0];
          state_q  <= S_MASK1;
        end
        S_MASK1: begin
          we_q     <= 1'b1;
          addr_q   <= word_to_byte(AW'(MASK_BASE + 1));
          wrdata_q <= mask_q[2*BRAM_DATA_WIDTH-1:BRAM_DATA_WIDTH];
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.bram_addr   = addr_q;
  assign bus.bram_wrdata = wrdata_q;
  assign bus.bram_we     = {BYTES{we_q}};
  assign bus.done        = done_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_zs_packer.sv
// Self-checking bench for zs_packer: directed and random A matrices checked
// against a row-by-row compression model and a BRAM shadow memory.
module tb_zs_packer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  zs_packer_if bus ();

  zs_packer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] a_mat   [64];
  logic [31:0] mem     [128];
  logic [31:0] exp_mem [32];
  logic [63:0] exp_mask;
  logic        exp_ovf;
  int          exp_stored;
  int          wr_cnt, done_cnt, bad_we;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Shadow BRAM, sampled mid-cycle on the registered write port.
  always @(negedge clk) begin
    if (bus.bram_we != '0) begin
      int widx;
      widx = int'(bus.bram_addr) / 4;
      wr_cnt++;
      if (bus.bram_we != 4'hF || widx >= 128) bad_we++;
      else mem[widx] = bus.bram_wrdata;
    end
    if (bus.done) done_cnt++;
  end

  // Each row keeps its first four nonzeros in column order, zero-padded.
  task automatic model();
    int n;
    exp_mask   = '0;
    exp_ovf    = 1'b0;
    exp_stored = 0;
    for (int r = 0; r < 8; r++) begin
      n = 0;
      for (int s = 0; s < 4; s++) exp_mem[r*4+s] = 32'h0;
      for (int c = 0; c < 8; c++) begin
        if (a_mat[r*8+c] != 32'h0) begin
          if (n < 4) begin
            exp_mem[r*4+n]  = a_mat[r*8+c];
            exp_mask[r*8+c] = 1'b1;
            exp_stored++;
          end else begin
            exp_ovf = 1'b1;
          end
          n++;
        end
      end
    end
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < 128; i++) mem[i] = 32'hDEAD_BEEF;
    wr_cnt = 0; done_cnt = 0; bad_we = 0;
  endtask

  task automatic run_image(input bit gaps, input string tag);
    int idx, cycles, min_cycles;
    bit hs;
    model();
    clear_shadow();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check({tag, ".ovf_clr"}, bus.overflow, 0);
    idx = 0; cycles = 0;
    while (!bus.done && cycles < 3000) begin
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = (bus.in_valid && idx < 64) ? a_mat[idx] : $urandom;
      hs = bus.in_valid && bus.in_ready;
      @(negedge clk);
      cycles++;
      if (hs) idx++;
    end
    bus.in_valid = 1'b0;
    min_cycles = 64 + (32 - exp_stored) + 3;
    check({tag, ".done_seen"}, bus.done, 1);
    check({tag, ".accepted"}, idx, 64);
    if (gaps) check({tag, ".cycles_min"}, cycles >= min_cycles, 1);
    else      check({tag, ".cycles"}, cycles, min_cycles);
    @(negedge clk);
    check({tag, ".done_pulse"}, bus.done, 0);
    check({tag, ".done_cnt"}, done_cnt, 1);
    check({tag, ".wr_cnt"}, wr_cnt, 34);
    check({tag, ".bad_we"}, bad_we, 0);
    check({tag, ".overflow"}, bus.overflow, exp_ovf);
    for (int w = 0; w < 32; w++)
      check($sformatf("%s.w%0d", tag, w), mem[w], exp_mem[w]);
    check({tag, ".mask_lo"}, mem[96], exp_mask[31:0]);
    check({tag, ".mask_hi"}, mem[97], exp_mask[63:32]);
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 64; i++) a_mat[i] = v;
  endtask

  task automatic fill_random();
    int dens;
    dens = $urandom_range(1, 7);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 7) < dens)
        a_mat[i] = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : ($urandom | 32'h1);
      else
        a_mat[i] = 32'h0;
    end
  endtask

  initial begin
    int idx, cycles;
    bit hs;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    clear_shadow();

    repeat (3) @(negedge clk);
    check("rst.in_ready", bus.in_ready, 0);
    check("rst.we", bus.bram_we, 0);
    check("rst.done", bus.done, 0);
    check("rst.overflow", bus.overflow, 0);
    check("rst.addr", bus.bram_addr, 0);
    check("rst.wrdata", bus.bram_wrdata, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle.in_ready", bus.in_ready, 0);

    fill(32'h0);
    run_image(1'b0, "zero");

    fill(32'h0);
    for (int r = 0; r < 8; r++) a_mat[r*9] = 32'h1;
    run_image(1'b0, "ident");
    check("ident.lo_const", mem[96], 32'h0804_0201);
    check("ident.hi_const", mem[97], 32'h8040_2010);

    fill(32'h0);
    for (int c = 0; c < 8; c++) a_mat[c] = 32'(c + 1);
    run_image(1'b0, "row0full");
    repeat (5) @(negedge clk);
    check("row0full.ovf_sticky", bus.overflow, 1);

    fill(32'h0);
    a_mat[2*8+5] = 32'h8000_0000;
    run_image(1'b0, "negzero");
    check("negzero.w8", mem[8], 32'h8000_0000);
    check("negzero.bit21", mem[96][21], 1);

    fill_random();
    run_image(1'b0, "fixed_nogap");
    run_image(1'b1, "fixed_gap");

    for (int k = 0; k < 4; k++) begin
      fill_random();
      run_image(1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end

    // Abort a run while row 0 is padding, then pack the identity matrix.
    fill_random();
    for (int c = 0; c < 8; c++) a_mat[c] = 32'h0;
    a_mat[1] = 32'h5; a_mat[3] = 32'h6;
    clear_shadow();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    idx = 0; cycles = 0;
    while (!(idx == 8 && !bus.in_ready) && cycles < 200) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (idx < 64) ? a_mat[idx] : 32'h0;
      hs = bus.in_valid && bus.in_ready;
      @(negedge clk);
      cycles++;
      if (hs) idx++;
    end
    check("abort.idx", idx, 8);
    check("abort.in_pad", bus.in_ready, 0);
    resetn = 1'b0;
    @(negedge clk);
    check("abort.we", bus.bram_we, 0);
    check("abort.done", bus.done, 0);
    check("abort.in_ready", bus.in_ready, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.no_mask_lo", mem[96], 32'hDEAD_BEEF);
    check("abort.no_mask_hi", mem[97], 32'hDEAD_BEEF);
    check("abort.w0", mem[0], 32'h5);

    fill(32'h0);
    for (int r = 0; r < 8; r++) a_mat[r*9] = 32'h1;
    run_image(1'b1, "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
